// File: rtl/port_pkg.sv
// Shared definitions for the switch output-port path: word field widths,
// packet class encoding and target-mask classification.
package port_pkg;

  localparam int DATA_W = 8;
  localparam int SRC_W  = 4;
  localparam int TGT_W  = 4;
  localparam int WORD_W = DATA_W + SRC_W + TGT_W;

  typedef enum logic [1:0] {
    KIND_UNKNOWN = 2'd0,
    KIND_SINGLE  = 2'd1,
    KIND_MULTI   = 2'd2,
    KIND_BCAST   = 2'd3
  } pkt_kind_t;

  // One-hot test: clearing the lowest set bit of a non-zero mask leaves zero.
  function automatic pkt_kind_t classify_target(input logic [TGT_W-1:0] tgt);
    if (tgt == '0)
      return KIND_UNKNOWN;
    else if (tgt == '1)
      return KIND_BCAST;
    else if ((tgt & (tgt - TGT_W'(1))) == '0)
      return KIND_SINGLE;
    else
      return KIND_MULTI;
  endfunction

endpackage

// File: rtl/egress_fifo.sv
// Packet FIFO for the egress buffer: power-of-two depth, naturally wrapping
// pointers, head word visible combinationally at rdata.
module egress_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/port_egress_buffer.sv
// Egress buffer for one switch output port: filters misrouted words, classifies
// and queues the rest, and keeps saturating per-class statistics.
module port_egress_buffer
  import port_pkg::*;
#(
  parameter int PORT_ID = 0,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_op,
  input  logic        valid_op,
  output logic        suspend_op,
  output logic [15:0] pkt_data,
  output logic [1:0]  pkt_kind,
  output logic        pkt_valid,
  input  logic        pkt_ready,
  input  logic        clr,
  output logic [7:0]  cnt_single,
  output logic [7:0]  cnt_multi,
  output logic [7:0]  cnt_bcast,
  output logic [7:0]  cnt_err
);

  localparam int ENTRY_W = WORD_W + 2;

  logic [TGT_W-1:0]   tgt;
  pkt_kind_t          in_kind;
  logic               misrouted, accept, push, err_inc, pop;
  logic               fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] head;

  assign tgt       = data_op[TGT_W-1:0];
  assign in_kind   = classify_target(tgt);
  assign misrouted = (tgt == '0) || !tgt[PORT_ID];
  // suspend_op is a pure register decode, so accept never loops back through it
  assign accept    = valid_op && !suspend_op;
  assign push      = accept && !misrouted;
  assign err_inc   = accept && misrouted;
  assign pop       = pkt_valid && pkt_ready;

  egress_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({in_kind, data_op}),
    .rdata (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign suspend_op = fifo_full;
  assign pkt_valid  = !fifo_empty;
  assign pkt_data   = pkt_valid ? head[WORD_W-1:0] : '0;
  assign pkt_kind   = pkt_valid ? head[ENTRY_W-1:WORD_W] : 2'd0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_single <= '0;
      cnt_multi  <= '0;
      cnt_bcast  <= '0;
      cnt_err    <= '0;
    end else if (clr) begin
      cnt_single <= '0;
      cnt_multi  <= '0;
      cnt_bcast  <= '0;
      cnt_err    <= '0;
    end else begin
      if (push && in_kind == KIND_SINGLE && cnt_single != 8'hFF)
        cnt_single <= cnt_single + 8'd1;
      if (push && in_kind == KIND_MULTI && cnt_multi != 8'hFF)
        cnt_multi <= cnt_multi + 8'd1;
      if (push && in_kind == KIND_BCAST && cnt_bcast != 8'hFF)
        cnt_bcast <= cnt_bcast + 8'd1;
      if (err_inc && cnt_err != 8'hFF)
        cnt_err <= cnt_err + 8'd1;
    end
  end

endmodule

// File: tb/tb_port_egress_buffer.sv
// Directed bench for port_egress_buffer at PORT_ID=1, DEPTH=4: a vector table
// for routing/classification plus sequences for full, order, saturation and reset.
module tb_port_egress_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_op;
  logic        valid_op;
  logic        suspend_op;
  logic [15:0] pkt_data;
  logic [1:0]  pkt_kind;
  logic        pkt_valid;
  logic        pkt_ready;
  logic        clr;
  logic [7:0]  cnt_single, cnt_multi, cnt_bcast, cnt_err;

  int n_cmp  = 0;
  int n_fail = 0;

  port_egress_buffer #(.PORT_ID(1), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_op    (data_op),
    .valid_op   (valid_op),
    .suspend_op (suspend_op),
    .pkt_data   (pkt_data),
    .pkt_kind   (pkt_kind),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .clr        (clr),
    .cnt_single (cnt_single),
    .cnt_multi  (cnt_multi),
    .cnt_bcast  (cnt_bcast),
    .cnt_err    (cnt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic        exp_valid;
    logic [1:0]  exp_kind;
    logic [7:0]  es, em, eb, ee;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // word, valid, kind, cumulative single/multi/bcast/err
    vecs[0] = '{16'hA502, 1'b1, 2'd1, 8'd1, 8'd0, 8'd0, 8'd0};
    vecs[1] = '{16'h1104, 1'b0, 2'd0, 8'd1, 8'd0, 8'd0, 8'd1};
    vecs[2] = '{16'h2200, 1'b0, 2'd0, 8'd1, 8'd0, 8'd0, 8'd2};
    vecs[3] = '{16'h3306, 1'b1, 2'd2, 8'd1, 8'd1, 8'd0, 8'd2};
    vecs[4] = '{16'h12FF, 1'b1, 2'd3, 8'd1, 8'd1, 8'd1, 8'd2};
    vecs[5] = '{16'h0003, 1'b1, 2'd2, 8'd1, 8'd2, 8'd1, 8'd2};
    vecs[6] = '{16'h0001, 1'b0, 2'd0, 8'd1, 8'd2, 8'd1, 8'd3};
    vecs[7] = '{16'h000E, 1'b1, 2'd2, 8'd1, 8'd3, 8'd1, 8'd3};
    vecs[8] = '{16'h0008, 1'b0, 2'd0, 8'd1, 8'd3, 8'd1, 8'd4};
    vecs[9] = '{16'hFF0A, 1'b1, 2'd2, 8'd1, 8'd4, 8'd1, 8'd4};

    reset     = 1'b0;
    data_op   = '0;
    valid_op  = 1'b0;
    pkt_ready = 1'b0;
    clr       = 1'b0;
    #2;
    chk("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    chk("rst_pkt_data", 32'(pkt_data), 32'd0);
    chk("rst_pkt_kind", 32'(pkt_kind), 32'd0);
    chk("rst_suspend", 32'(suspend_op), 32'd0);
    chk("rst_cnt_single", 32'(cnt_single), 32'd0);
    chk("rst_cnt_err", 32'(cnt_err), 32'd0);
    #11;
    reset = 1'b1;
    step();

    // Routing and classification table
    for (int i = 0; i < 10; i++) begin
      data_op  = vecs[i].word;
      valid_op = 1'b1;
      step();
      valid_op = 1'b0;
      data_op  = '0;
      chk($sformatf("v%0d_valid", i), 32'(pkt_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_data", i), 32'(pkt_data), vecs[i].exp_valid ? 32'(vecs[i].word) : 32'd0);
      chk($sformatf("v%0d_kind", i), 32'(pkt_kind), 32'(vecs[i].exp_kind));
      chk($sformatf("v%0d_single", i), 32'(cnt_single), 32'(vecs[i].es));
      chk($sformatf("v%0d_multi", i), 32'(cnt_multi), 32'(vecs[i].em));
      chk($sformatf("v%0d_bcast", i), 32'(cnt_bcast), 32'(vecs[i].eb));
      chk($sformatf("v%0d_err", i), 32'(cnt_err), 32'(vecs[i].ee));
      if (vecs[i].exp_valid) begin
        pkt_ready = 1'b1;
        step();
        pkt_ready = 1'b0;
        chk($sformatf("v%0d_popped", i), 32'(pkt_valid), 32'd0);
      end
    end

    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_single", 32'(cnt_single), 32'd0);
    chk("clr_multi", 32'(cnt_multi), 32'd0);
    chk("clr_bcast", 32'(cnt_bcast), 32'd0);
    chk("clr_err", 32'(cnt_err), 32'd0);

    // Fill to DEPTH with the consumer stalled; fifth word must wait
    data_op  = 16'h5A3F;
    valid_op = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      if (i == 3) chk("fill3_suspend", 32'(suspend_op), 32'd0);
      if (i == 4) chk("fill4_suspend", 32'(suspend_op), 32'd1);
    end
    chk("full_suspend", 32'(suspend_op), 32'd1);
    chk("full_bcast", 32'(cnt_bcast), 32'd4);
    chk("full_hold_data", 32'(pkt_data), 32'h5A3F);
    pkt_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain%0d_valid", i), 32'(pkt_valid), 32'd1);
      chk($sformatf("drain%0d_data", i), 32'(pkt_data), 32'h5A3F);
      chk($sformatf("drain%0d_kind", i), 32'(pkt_kind), 32'd3);
      step();
      if (i == 0) chk("drain0_suspend", 32'(suspend_op), 32'd0);
      if (i == 0) chk("drain0_bcast", 32'(cnt_bcast), 32'd4);
      if (i == 1) valid_op = 1'b0;
    end
    pkt_ready = 1'b0;
    chk("drain_empty", 32'(pkt_valid), 32'd0);
    chk("drain_bcast", 32'(cnt_bcast), 32'd5);

    // Simultaneous push and pop at count 2
    valid_op = 1'b1;
    data_op  = 16'h1102;
    step();
    data_op  = 16'h2206;
    step();
    chk("ord_head0", 32'(pkt_data), 32'h1102);
    data_op   = 16'h770F;
    pkt_ready = 1'b1;
    step();
    valid_op = 1'b0;
    data_op  = '0;
    chk("ord_head1", 32'(pkt_data), 32'h2206);
    chk("ord_kind1", 32'(pkt_kind), 32'd2);
    step();
    chk("ord_head2", 32'(pkt_data), 32'h770F);
    chk("ord_kind2", 32'(pkt_kind), 32'd3);
    step();
    chk("ord_empty", 32'(pkt_valid), 32'd0);

    // Saturation, then clr winning over a same-cycle increment
    clr = 1'b1;
    step();
    clr      = 1'b0;
    data_op  = 16'h0002;
    valid_op = 1'b1;
    for (int i = 1; i <= 260; i++) begin
      step();
      if (i == 254) chk("sat254", 32'(cnt_single), 32'd254);
      if (i == 255) chk("sat255", 32'(cnt_single), 32'd255);
    end
    chk("sat260", 32'(cnt_single), 32'd255);
    chk("sat_no_suspend", 32'(suspend_op), 32'd0);
    clr = 1'b1;
    step();
    clr      = 1'b0;
    valid_op = 1'b0;
    chk("clr_prio_single", 32'(cnt_single), 32'd0);
    step();
    pkt_ready = 1'b0;
    chk("sat_drained", 32'(pkt_valid), 32'd0);

    // Asynchronous reset with packets queued
    data_op  = 16'h3306;
    valid_op = 1'b1;
    step();
    step();
    valid_op = 1'b0;
    data_op  = '0;
    chk("pre_rst_multi", 32'(cnt_multi), 32'd2);
    chk("pre_rst_valid", 32'(pkt_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(pkt_valid), 32'd0);
    chk("arst_suspend", 32'(suspend_op), 32'd0);
    chk("arst_multi", 32'(cnt_multi), 32'd0);
    chk("arst_data", 32'(pkt_data), 32'd0);
    #1;
    reset = 1'b1;
    data_op  = 16'h4402;
    valid_op = 1'b1;
    step();
    valid_op = 1'b0;
    data_op  = '0;
    chk("post_rst_head", 32'(pkt_data), 32'h4402);
    chk("post_rst_kind", 32'(pkt_kind), 32'd1);
    pkt_ready = 1'b1;
    step();
    pkt_ready = 1'b0;
    chk("post_rst_empty", 32'(pkt_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/port_egress_buffer.md
PORT_EGRESS_BUFFER -- requirements
Module: port_egress_buffer

Interface
REQ-001 SHALL have parameter PORT_ID, default 0, meaning the index (0-3) of the switch output port this block consumes.
REQ-002 SHALL have parameter DEPTH, default 4, meaning the FIFO depth in packets; legal values are powers of two from 2 to 16.
REQ-003 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port data_op  input  16  switch output word {data[15:8], source[7:4], target[3:0]}.
REQ-006 SHALL have port valid_op  input  1  switch output word valid.
REQ-007 SHALL have port suspend_op  output  1  backpressure to the switch; while high, the switch holds data_op and valid_op.
REQ-008 SHALL have port pkt_data  output  16  head-of-FIFO word.
REQ-009 SHALL have port pkt_kind  output  2  head-of-FIFO class: 0 UNKNOWN, 1 SINGLE, 2 MULTICAST, 3 BROADCAST.
REQ-010 SHALL have port pkt_valid  output  1  head-of-FIFO valid.
REQ-011 SHALL have port pkt_ready  input  1  downstream consumer accepts the head.
REQ-012 SHALL have port clr  input  1  synchronous clear of all statistics counters.
REQ-013 SHALL have ports cnt_single, cnt_multi, cnt_bcast, cnt_err  output  8 each  saturating packet counters.

Function
REQ-014 SHALL accept a word on a rising edge when valid_op=1 and suspend_op=0.
REQ-015 SHALL drive suspend_op high exactly when the stored count equals DEPTH, decoded from registers only, with no combinational path from any input.
REQ-016 SHALL classify target as follows: 0000 -> UNKNOWN; 1111 -> BROADCAST; one-hot -> SINGLE; any other value -> MULTICAST.
REQ-017 SHALL treat an accepted word as misrouted if target[PORT_ID]=0 or target=0000; a misrouted word SHALL NOT be stored and SHALL increment cnt_err.
REQ-018 SHALL store each accepted, correctly routed word together with its pkt_kind, and SHALL increment the matching counter in the same cycle.
REQ-019 SHALL present a stored word on pkt_valid/pkt_data/pkt_kind in the cycle after acceptance (latency 1), in arrival order.
REQ-020 SHALL pop the head on a rising edge when pkt_valid=1 and pkt_ready=1, and SHALL hold pkt_data and pkt_kind stable while pkt_valid=1 and pkt_ready=0.
REQ-021 SHALL leave the count unchanged on a simultaneous push and pop, and SHALL never push while suspend_op=1.
REQ-022 SHALL NOT push when the FIFO is full, even if a pop occurs in the same cycle; suspend_op is already high in that cycle.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH.
REQ-024 SHALL saturate every counter at 255 and never wrap it.
REQ-025 SHALL give clr priority over an increment in the same cycle (result 0); clr SHALL NOT affect FIFO contents.
REQ-026 SHALL hold pkt_data and pkt_kind at 0 while pkt_valid=0.

Reset
REQ-027 SHALL, while reset=0, immediately force: pointers and count to 0, pkt_valid=0, pkt_data=0, pkt_kind=0, suspend_op=0, and all counters to 0.
REQ-028 SHALL discard packets stored before a mid-operation reset; after reset release, the first accepted word SHALL be the first one output.

Structure
REQ-029 SHALL take from the shared package port_pkg: typedef pkt_kind_t (the 2-bit enum), field-width constants DATA_W=8, SRC_W=4, TGT_W=4, and function classify_target.
REQ-030 SHALL implement storage as one sub-module, egress_fifo, parameterised by width (18 bits: word plus kind) and DEPTH; the counters and classification SHALL live in the top level.

Verification
REQ-031 SHALL cover: PORT_ID=1, drive 16'hA502 (data A5, source 0, target 2) -> next cycle pkt_valid=1, pkt_data=16'hA502, pkt_kind=1, cnt_single=1.
REQ-032 SHALL cover: DEPTH=4, pkt_ready=0, five 16'h5A3F words -> suspend_op=1 after the 4th acceptance, 5th held; then pkt_ready=1 -> all five output in order with pkt_kind=3, cnt_bcast=5.
REQ-033 SHALL cover: PORT_ID=1, drive 16'h1104 and 16'h2200 -> pkt_valid stays 0, cnt_err=2.
REQ-034 SHALL cover: 260 words 16'h0002 at PORT_ID=1 with pkt_ready=1 -> cnt_single=255; then clr=1 for one cycle -> cnt_single=0.
REQ-035 SHALL cover: two words 16'h3306 stored (kind MULTICAST), then reset=0 mid-cycle -> pkt_valid=0, suspend_op=0, cnt_multi=0 without waiting for a clock edge.
REQ-036 SHALL cover: count=2, simultaneous accept of 16'h770F and pop -> count remains 2, order preserved.
